if_fetch_stage: RTL and testbench



---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pc_next_mux.sv | 28 ++
 rtl/if_fetch_stage.sv | 139 +++++++++++++
 tb/tb_if_fetch_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: word width, next-PC select codes, fetch FSM
// state encoding and the default bubble encoding.
package pipe_pkg;

  localparam int WORD_W = 32;

  // Next-PC select codes driven by the PC controller
  localparam logic [1:0] PCSEL_SEQ  = 2'd0;
  localparam logic [1:0] PCSEL_BR   = 2'd1;
  localparam logic [1:0] PCSEL_JMP  = 2'd2;
  localparam logic [1:0] PCSEL_HOLD = 2'd3;

  // Default encoding written into IF/ID for a bubble
  localparam logic [WORD_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Fetch FSM states
  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HELD  = 2'd2,
    FS_DRAIN = 2'd3
  } fetch_state_e;

  // Instruction addresses are word aligned; low two bits are dropped
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational 4:1 next-PC select with forced word alignment.
module pc_next_mux
  import pipe_pkg::*;
(
  input  logic [1:0]        pcsel,
  input  logic [WORD_W-1:0] pc_plus4,
  input  logic [WORD_W-1:0] br_target,
  input  logic [WORD_W-1:0] jmp_target,
  input  logic [WORD_W-1:0] pcp4_hold,
  output logic [WORD_W-1:0] next_pc
);

  logic [WORD_W-1:0] selected;

  // Pick the candidate address, then clear its low two bits
  always_comb begin
    selected = pc_plus4;
    case (pcsel)
      PCSEL_SEQ:  selected = pc_plus4;
      PCSEL_BR:   selected = br_target;
      PCSEL_JMP:  selected = jmp_target;
      PCSEL_HOLD: selected = pcp4_hold;
      default:    selected = pc_plus4;
    endcase
    next_pc = align_word(selected);
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: holds the PC, runs a single-outstanding fetch
// from instruction memory and writes the IF/ID pipeline register, with
// bubble insertion and a one-entry skid buffer for stalls.
//
// Memory handshake: imem_req is a request held high together with a stable
// imem_addr until the cycle in which imem_ready is sampled high; that cycle
// completes the fetch and imem_rdata is valid only in it. imem_ready seen
// while imem_req is low is ignored.
module if_fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pcsel,
  input  logic [31:0] br_target,
  input  logic [31:0] jmp_target,
  input  logic [31:0] pcp4_hold,
  input  logic        if_id_retire,
  input  logic        stall,
  output logic [31:0] pcp4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pcp4,
  output logic        if_id_valid,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_IDLE  = FS_IDLE;
  localparam logic [1:0] ST_FETCH = FS_FETCH;
  localparam logic [1:0] ST_HELD  = FS_HELD;
  localparam logic [1:0] ST_DRAIN = FS_DRAIN;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] redirect_pc;
  logic [31:0] skid_instr;
  logic [31:0] skid_pcp4;
  logic        redirect_req;

  pc_next_mux u_pc_next_mux (
    .pcsel      (pcsel),
    .pc_plus4   (pcp4),
    .br_target  (br_target),
    .jmp_target (jmp_target),
    .pcp4_hold  (pcp4_hold),
    .next_pc    (next_pc)
  );

  // Fall-through address, request and debug state decode
  always_comb begin
    pcp4         = pc + 32'd4;
    imem_addr    = pc;
    imem_req     = (state == ST_FETCH) || (state == ST_DRAIN);
    redirect_req = (pcsel != PCSEL_SEQ) && !stall;
    dbg_state    = state;
  end

  // Fetch FSM, PC, redirect register, skid buffer and IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      redirect_pc <= 32'h0;
      skid_instr  <= 32'h0;
      skid_pcp4   <= 32'h0;
      if_id_instr <= NOP_INSTR;
      if_id_pcp4  <= 32'h0;
      if_id_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_FETCH;
        end

        ST_FETCH: begin
          if (imem_ready) begin
            if (!stall) begin
              // Completed fetch goes straight into IF/ID; stay fetching
              if_id_instr <= if_id_retire ? NOP_INSTR : imem_rdata;
              if_id_pcp4  <= pcp4;
              if_id_valid <= !if_id_retire;
              pc          <= next_pc;
            end else begin
              // IF/ID is frozen, so park the returned word
              skid_instr <= imem_rdata;
              skid_pcp4  <= pcp4;
              state      <= ST_HELD;
            end
          end else if (!stall) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            if (redirect_req) begin
              // Request is still outstanding: remember where to go once
              // memory answers, and throw that answer away
              redirect_pc <= next_pc;
              state       <= ST_DRAIN;
            end
          end
        end

        ST_HELD: begin
          if (!stall) begin
            if_id_instr <= if_id_retire ? NOP_INSTR : skid_instr;
            if_id_pcp4  <= skid_pcp4;
            if_id_valid <= !if_id_retire;
            pc          <= next_pc;
            state       <= ST_FETCH;
          end
        end

        ST_DRAIN: begin
          if (!stall) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end
          if (imem_ready) begin
            // A redirect arriving on the completing edge still wins
            pc    <= redirect_req ? next_pc : redirect_pc;
            state <= ST_FETCH;
          end else if (redirect_req) begin
            redirect_pc <= next_pc;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: sequential fetch, branch/hold/jump
// redirects with retire, stall into the skid buffer, drain of an
// outstanding request, last-redirect-wins, reset mid-drain and PC wrap.
module tb_if_fetch_stage;
  import pipe_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [1:0]  pcsel;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic [31:0] pcp4_hold;
  logic        if_id_retire;
  logic        stall;
  logic [31:0] pcp4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pcp4;
  logic        if_id_valid;
  logic [1:0]  dbg_state;

  int checks;
  int errors;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .pcsel        (pcsel),
    .br_target    (br_target),
    .jmp_target   (jmp_target),
    .pcp4_hold    (pcp4_hold),
    .if_id_retire (if_id_retire),
    .stall        (stall),
    .pcp4         (pcp4),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .if_id_instr  (if_id_instr),
    .if_id_pcp4   (if_id_pcp4),
    .if_id_valid  (if_id_valid),
    .dbg_state    (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pcsel = PCSEL_SEQ; br_target = '0; jmp_target = '0; pcp4_hold = '0;
    if_id_retire = 1'b0; stall = 1'b0; imem_rdata = '0; imem_ready = 1'b0;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", if_id_valid); end
    checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL rst_instr got %h exp %h", if_id_instr, NOP); end
    checks++; if (if_id_pcp4 !== 32'h0) begin errors++; $display("FAIL rst_ifid_pcp4 got %h exp 0", if_id_pcp4); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
    checks++; if (pcp4 !== 32'h4) begin errors++; $display("FAIL rst_pcp4 got %h exp 4", pcp4); end
    checks++; if (dbg_state !== 2'(FS_IDLE)) begin errors++; $display("FAIL rst_state got %0d exp %0d", dbg_state, FS_IDLE); end
  endtask

  task automatic test_sequential();
    rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hBAD0_0000;
    step();  // IDLE -> FETCH; ready is not a completion here
    checks++; if (dbg_state !== 2'(FS_FETCH)) begin errors++; $display("FAIL seq_state got %0d exp %0d", dbg_state, FS_FETCH); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL seq_first req %b addr %h exp 1 0", imem_req, imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL seq_idle_ready got %b exp 0", if_id_valid); end
    for (int i = 0; i < 4; i++) begin
      imem_rdata = 32'hA000_0000 + 32'(i * 4);
      step();
      checks++; if (imem_addr !== 32'((i + 1) * 4)) begin errors++; $display("FAIL seq_addr%0d got %h exp %h", i, imem_addr, (i + 1) * 4); end
      checks++; if (if_id_pcp4 !== 32'((i + 1) * 4) || if_id_valid !== 1'b1) begin errors++; $display("FAIL seq_ifid%0d pcp4 %h valid %b exp %h 1", i, if_id_pcp4, if_id_valid, (i + 1) * 4); end
      checks++; if (if_id_instr !== 32'hA000_0000 + 32'(i * 4)) begin errors++; $display("FAIL seq_instr%0d got %h exp %h", i, if_id_instr, 32'hA000_0000 + 32'(i * 4)); end
    end
  endtask

  task automatic test_branch_retire();
    pcsel = PCSEL_BR; br_target = 32'h40; if_id_retire = 1'b1; imem_rdata = 32'h1111_0010;
    step();
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin errors++; $display("FAIL br_bubble valid %b instr %h exp 0 %h", if_id_valid, if_id_instr, NOP); end
    checks++; if (if_id_pcp4 !== 32'h14) begin errors++; $display("FAIL br_pcp4 got %h exp 14", if_id_pcp4); end
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL br_addr got %h exp 40", imem_addr); end
  endtask

  task automatic test_hold_redirect();
    pcsel = PCSEL_HOLD; pcp4_hold = 32'h14; if_id_retire = 1'b1; imem_rdata = 32'h2222_0040;
    step();
    checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL hold_addr got %h exp 14", imem_addr); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin errors++; $display("FAIL hold_bubble valid %b instr %h", if_id_valid, if_id_instr); end
  endtask

  task automatic test_jump_align();
    pcsel = PCSEL_JMP; jmp_target = 32'h22; if_id_retire = 1'b1; imem_rdata = 32'h3333_0014;
    step();
    checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL jmp_align got %h exp 20", imem_addr); end
    pcsel = PCSEL_SEQ; if_id_retire = 1'b0;
  endtask

  task automatic test_stall_skid();
    imem_ready = 1'b1; imem_rdata = 32'hCAFE_0020; stall = 1'b1;
    step();
    checks++; if (dbg_state !== 2'(FS_HELD) || imem_req !== 1'b0) begin errors++; $display("FAIL stall_held state %0d req %b exp %0d 0", dbg_state, imem_req, FS_HELD); end
    imem_rdata = 32'hDEAD_BEEF; pcsel = PCSEL_BR; br_target = 32'h80; if_id_retire = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h20) begin errors++; $display("FAIL stall_hold%0d req %b addr %h exp 0 20", i, imem_req, imem_addr); end
      checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin errors++; $display("FAIL stall_ifid%0d valid %b instr %h", i, if_id_valid, if_id_instr); end
    end
    pcsel = PCSEL_SEQ; if_id_retire = 1'b0; stall = 1'b0;
    step();
    checks++; if (if_id_instr !== 32'hCAFE_0020) begin errors++; $display("FAIL skid_instr got %h exp cafe0020", if_id_instr); end
    checks++; if (if_id_pcp4 !== 32'h24 || if_id_valid !== 1'b1) begin errors++; $display("FAIL skid_pcp4 %h valid %b exp 24 1", if_id_pcp4, if_id_valid); end
    checks++; if (imem_addr !== 32'h24 || imem_req !== 1'b1) begin errors++; $display("FAIL skid_next addr %h req %b exp 24 1", imem_addr, imem_req); end
  endtask

  task automatic test_back_to_back();
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_rdata = 32'hB000_0024 + 32'(i * 4);
      step();
      checks++; if (if_id_pcp4 !== 32'h28 + 32'(i * 4) || if_id_instr !== imem_rdata || if_id_valid !== 1'b1) begin
        errors++; $display("FAIL b2b%0d pcp4 %h instr %h valid %b exp %h %h 1", i, if_id_pcp4, if_id_instr, if_id_valid, 32'h28 + 32'(i * 4), imem_rdata);
      end
      checks++; if (imem_addr !== 32'h28 + 32'(i * 4)) begin errors++; $display("FAIL b2b_addr%0d got %h exp %h", i, imem_addr, 32'h28 + 32'(i * 4)); end
    end
  endtask

  task automatic test_drain();
    imem_ready = 1'b0; pcsel = PCSEL_JMP; jmp_target = 32'h100;
    step();
    checks++; if (dbg_state !== 2'(FS_DRAIN)) begin errors++; $display("FAIL drain_state got %0d exp %0d", dbg_state, FS_DRAIN); end
    checks++; if (imem_addr !== 32'h30 || imem_req !== 1'b1) begin errors++; $display("FAIL drain_hold1 addr %h req %b exp 30 1", imem_addr, imem_req); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL drain_bubble got %b exp 0", if_id_valid); end
    pcsel = PCSEL_SEQ;
    step();
    checks++; if (imem_addr !== 32'h30 || imem_req !== 1'b1) begin errors++; $display("FAIL drain_hold2 addr %h req %b exp 30 1", imem_addr, imem_req); end
    imem_ready = 1'b1; imem_rdata = 32'hBAD0_0030;
    step();
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL drain_target got %h exp 100", imem_addr); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin errors++; $display("FAIL drain_discard valid %b instr %h", if_id_valid, if_id_instr); end
    checks++; if (dbg_state !== 2'(FS_FETCH)) begin errors++; $display("FAIL drain_exit got %0d exp %0d", dbg_state, FS_FETCH); end
  endtask

  task automatic test_last_redirect();
    imem_ready = 1'b0; pcsel = PCSEL_BR; br_target = 32'h180;
    step();
    pcsel = PCSEL_JMP; jmp_target = 32'h200;
    step();
    pcsel = PCSEL_SEQ; imem_ready = 1'b1; imem_rdata = 32'hBAD0_0100;
    step();
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL last_redirect got %h exp 200", imem_addr); end
  endtask

  task automatic test_reset_in_drain();
    imem_ready = 1'b0; pcsel = PCSEL_JMP; jmp_target = 32'h300;
    step();
    checks++; if (dbg_state !== 2'(FS_DRAIN)) begin errors++; $display("FAIL rd_pre got %0d exp %0d", dbg_state, FS_DRAIN); end
    pcsel = PCSEL_SEQ; rst = 1'b1;
    step();
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b0 || if_id_valid !== 1'b0) begin
      errors++; $display("FAIL rd_reset addr %h req %b valid %b exp 0 0 0", imem_addr, imem_req, if_id_valid);
    end
    rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hBAD0_0200;
    step();
    checks++; if (if_id_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL rd_stale valid %b addr %h exp 0 0", if_id_valid, imem_addr); end
  endtask

  task automatic test_wrap();
    pcsel = PCSEL_JMP; jmp_target = 32'hFFFF_FFFC; imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    checks++; if (imem_addr !== 32'hFFFF_FFFC || pcp4 !== 32'h0) begin errors++; $display("FAIL wrap_pcp4 addr %h pcp4 %h exp fffffffc 0", imem_addr, pcp4); end
    checks++; if (if_id_pcp4 !== 32'h4 || if_id_valid !== 1'b1) begin errors++; $display("FAIL wrap_prev pcp4 %h valid %b exp 4 1", if_id_pcp4, if_id_valid); end
    pcsel = PCSEL_SEQ; imem_rdata = 32'h8765_4321;
    step();
    checks++; if (if_id_pcp4 !== 32'h0 || if_id_instr !== 32'h8765_4321) begin errors++; $display("FAIL wrap_ifid pcp4 %h instr %h exp 0 87654321", if_id_pcp4, if_id_instr); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", imem_addr); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_branch_retire();
    test_hold_redirect();
    test_jump_align();
    test_stall_skid();
    test_back_to_back();
    test_drain();
    test_last_redirect();
    test_reset_in_drain();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
